// File: rtl/boolean_expression_2_pkg.sv
// ============================================================================
// Module  : boolean_expression_2_pkg
// Purpose : Shared constants and helpers for the boolean_expression_2 block.
//           GOLDEN_TT is the reference truth table indexed by {A,B,C,D}
//           with A as the MSB. tt_lookup returns the golden value for one
//           minterm index.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package boolean_expression_2_pkg;

   localparam logic [15:0] GOLDEN_TT = 16'hCFE2;

   function automatic logic tt_lookup(input logic [3:0] idx);
      return GOLDEN_TT[idx];
   endfunction

endpackage

`default_nettype wire

// File: rtl/boolean_expression_2_sop.sv
// ============================================================================
// Module  : boolean_expression_2_sop
// Purpose : Purely combinational sum-of-products core.
//           y_o = (a & ~b) | (b & c) | (~a & ~c & d)
// Ports   : a_i, b_i, c_i, d_i - operands (a_i is the truth-table MSB)
//           y_o                - function result, zero latency
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module boolean_expression_2_sop (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   input  logic d_i,
   output logic y_o
);

   logic w_term0;
   logic w_term1;
   logic w_term2;

   assign w_term0 = a_i & ~b_i;
   assign w_term1 = b_i & c_i;
   assign w_term2 = ~a_i & ~c_i & d_i;

   // No masking: an X/Z on any operand propagates straight to y_o.
   assign y_o = w_term0 | w_term1 | w_term2;

endmodule

`default_nettype wire

// File: rtl/boolean_expression_2.sv
// ============================================================================
// Module  : boolean_expression_2
// Purpose : Four-input Boolean function evaluator with a registered copy of
//           the result and a one-cycle rising-edge flag.
// Ports   : clk    - system clock, rising-edge active
//           rst_n  - asynchronous active-low reset
//           A..D   - operands, {A,B,C,D} forms the truth-table index
//           Y      - combinational result, valid even during reset
//           y_q    - Y captured on each rising clk edge
//           y_rise - one-cycle pulse, one cycle after y_q goes 0 -> 1
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module boolean_expression_2
   import boolean_expression_2_pkg::*;
#(
   parameter logic [15:0] TRUTH_TABLE = GOLDEN_TT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic A,
   input  logic B,
   input  logic C,
   input  logic D,
   output logic Y,
   output logic y_q,
   output logic y_rise
);

   logic w_y;
   logic y_q_q,    y_q_d;
   logic prev_q,   prev_d;
   logic y_rise_q, y_rise_d;

   boolean_expression_2_sop u_sop (
      .a_i (A),
      .b_i (B),
      .c_i (C),
      .d_i (D),
      .y_o (w_y)
   );

   assign Y = w_y;

   // prev_q lags y_q_q by one cycle, so the edge detector compares the
   // current registered value with the one before it. The pulse therefore
   // appears one cycle after y_q rises and can never last two cycles.
   always_comb begin
      y_q_d    = w_y;
      prev_d   = y_q_q;
      y_rise_d = y_q_q & ~prev_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q_q    <= 1'b0;
         prev_q   <= 1'b0;
         y_rise_q <= 1'b0;
      end else begin
         y_q_q    <= y_q_d;
         prev_q   <= prev_d;
         y_rise_q <= y_rise_d;
      end
   end

   assign y_q    = y_q_q;
   assign y_rise = y_rise_q;

   // Simulation-only cross-check of the gate network against the table.
   // Sampled on the clock edge so that input changes are settled.
   logic [3:0] w_idx;
   assign w_idx = {A, B, C, D};

   always @(posedge clk) begin
      if (!$isunknown(w_idx)) begin
         assert (w_y == TRUTH_TABLE[w_idx]);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_boolean_expression_2.sv
// ============================================================================
// Module  : tb_boolean_expression_2
// Purpose : Self-checking bench for boolean_expression_2: table-driven
//           truth-table sweep, hand-written reset / edge sequences, and a
//           randomized run against a history-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_boolean_expression_2;
   import boolean_expression_2_pkg::*;

   logic clk;
   logic rst_n;
   logic A, B, C, D;
   logic Y, y_q, y_rise;

   int n_cmp;
   int n_fail;

   // History of y_q values after each clock edge (newest at the back).
   logic hist[$];

   boolean_expression_2 #(.TRUTH_TABLE(16'hCFE2)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .A      (A),
      .B      (B),
      .C      (C),
      .D      (D),
      .Y      (Y),
      .y_q    (y_q),
      .y_rise (y_rise)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] in;
      logic       exp_y;
   } vec_t;

   vec_t tbl[16];

   // Reference: Y is 1 exactly on the listed minterms.
   function automatic logic yref(input logic [3:0] v);
      return (v inside {4'd1, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
                        4'd10, 4'd11, 4'd14, 4'd15});
   endfunction

   task automatic check(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      hist.delete();
      hist.push_back(1'b0);
      hist.push_back(1'b0);
      hist.push_back(1'b0);
   endtask

   // Apply one input pattern for one clock cycle and check every output
   // against the model: y_q is the newest history entry, y_rise marks a
   // 0 -> 1 step between the two entries before it.
   task automatic step(input logic [3:0] v);
      {A, B, C, D} = v;
      #1;
      check("Y", Y, yref(v));
      tick();
      hist.push_back(yref(v));
      check("y_q", y_q, hist[$]);
      check("y_rise", y_rise, hist[$-1] & ~hist[$-2]);
   endtask

   initial begin
      int exp_seq[16] = '{0,1,0,0,0,1,1,1,1,1,1,1,0,0,1,1};
      logic prev_rise;

      n_cmp  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      {A, B, C, D} = 4'b0000;
      model_reset();

      for (int i = 0; i < 16; i++) begin
         tbl[i].in    = 4'(i);
         tbl[i].exp_y = exp_seq[i][0];
      end

      // Exhaustive sweep while held in reset.
      #2;
      check("reset_y_q", y_q, 1'b0);
      check("reset_y_rise", y_rise, 1'b0);
      for (int i = 0; i < 16; i++) begin
         {A, B, C, D} = tbl[i].in;
         #10;
         check("sweep_Y", Y, tbl[i].exp_y);
         check("sweep_pkg_tt", tt_lookup(tbl[i].in), tbl[i].exp_y);
      end

      // Reset hold with Y = 1: registers stay cleared.
      {A, B, C, D} = 4'b1000;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("hold_Y", Y, 1'b1);
         check("hold_y_q", y_q, 1'b0);
         check("hold_y_rise", y_rise, 1'b0);
      end

      // Release and capture with 0001.
      rst_n = 1'b1;
      model_reset();
      step(4'b0001);
      check("release_y_q", y_q, 1'b1);
      check("release_rise0", y_rise, 1'b0);
      step(4'b0001);
      check("release_rise1", y_rise, 1'b1);
      step(4'b0001);
      check("release_rise2", y_rise, 1'b0);

      // Falling transition 0111 -> 1100.
      step(4'b0111);
      step(4'b1100);
      check("fall_y_q", y_q, 1'b0);
      check("fall_y_rise", y_rise, 1'b0);

      // Async reset between edges.
      step(4'b0111);
      check("pre_async_y_q", y_q, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_y_q", y_q, 1'b0);
      check("async_y_rise", y_rise, 1'b0);
      {A, B, C, D} = 4'b1000;
      #1;
      check("async_Y_hi", Y, 1'b1);
      {A, B, C, D} = 4'b0000;
      #1;
      check("async_Y_lo", Y, 1'b0);
      tick();
      check("async_hold_y_q", y_q, 1'b0);
      rst_n = 1'b1;
      model_reset();

      // Toggle stress 0000 / 1111.
      prev_rise = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step((i % 2 == 0) ? 4'b0000 : 4'b1111);
         check("toggle_y_q", y_q, (i % 2 == 1));
         check("toggle_no_double_rise", y_rise & prev_rise, 1'b0);
         prev_rise = y_rise;
      end

      // Randomized run with occasional async resets.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            #2;
            rst_n = 1'b0;
            #1;
            check("rand_rst_y_q", y_q, 1'b0);
            check("rand_rst_y_rise", y_rise, 1'b0);
            tick();
            rst_n = 1'b1;
            model_reset();
         end
         step(4'($urandom_range(0, 15)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/boolean_expression_2.md
Name: boolean_expression_2

Overview:
- Four-input Boolean function evaluator. Produces a combinational result Y and a registered copy y_q, plus a single-cycle rising-edge flag.
- Used as a leaf logic block in the DSD exercise set. Combinational Y serves unclocked exhaustive truth-table sweeps; y_q and y_rise serve clocked consumers.

Parameters:
- TRUTH_TABLE, 16'hCFE2, golden truth table; bit index {A,B,C,D} (A = MSB) gives expected Y. Used only by assertions, not by the datapath.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous, active-low reset
- A  input  1  operand, MSB of truth-table index
- B  input  1  operand
- C  input  1  operand
- D  input  1  operand, LSB of truth-table index
- Y  output  1  combinational function result
- y_q  output  1  Y registered on the rising edge of clk
- y_rise  output  1  one-cycle pulse when y_q transitions 0 -> 1

Behaviour:
- Function: Y = (A & ~B) | (B & C) | (~A & ~C & D), implemented as sum-of-products gates.
- Y is 1 for minterms 1, 5, 6, 7, 8, 9, 10, 11, 14 and 15. Y is 0 for all other minterms.
- Y is purely combinational:
  - Zero latency, independent of clk and rst_n.
  - Valid whenever A..D are stable, including while reset is asserted.
- y_q:
  - Async clear to 0 on rst_n low.
  - Otherwise y_q <= Y on each rising clk edge; one-cycle latency.
- y_rise:
  - Async clear to 0.
  - Internal prev register (reset 0) holds the last y_q.
  - y_rise <= y_q & ~prev, registered, so it pulses one cycle after y_q rises.
  - Never asserts for two consecutive cycles.
- Reset deassertion: first capture on the next rising edge. If Y = 1 at that edge, y_q becomes 1 and y_rise pulses on the following cycle.
- Reset mid-operation: y_q, prev and y_rise go to 0 immediately; Y is unaffected.
- X/Z on any input propagates to Y; no masking logic.
- Simulation-only assertion: Y == TRUTH_TABLE[{A,B,C,D}] whenever inputs are known.

Decomposition:
- Package boolean_expression_2_pkg holds:
  - localparam GOLDEN_TT = 16'hCFE2
  - a helper function tt_lookup(logic [3:0] idx) returning GOLDEN_TT[idx], for bench and assertion use.
- One sub-module, boolean_expression_2_sop: pure combinational A, B, C, D -> Y core.
- Top level adds the y_q / prev / y_rise registers and the assertions.

Test Plan:
- Exhaustive sweep, no clock, rst_n = 0: drive {A,B,C,D} = 0..15 with 10 ns per step. Required Y sequence: 0,1,0,0,0,1,1,1,1,1,1,1,0,0,1,1.
- Reset hold: rst_n = 0, inputs 1000 (Y = 1), clk toggling -> y_q = 0 and y_rise = 0 throughout.
- Release and capture: deassert rst_n with inputs 0001.
  - First edge: y_q = 1.
  - Next edge: y_rise = 1.
  - Following edge: y_rise = 0.
- Falling transition: from 0111 (Y = 1) switch to 1100 (Y = 0) -> y_q = 0 one edge later; y_rise stays 0.
- Async reset mid-run: y_q = 1, then pull rst_n low between edges -> y_q = 0 immediately with no clk edge; Y still tracks inputs.
- Toggle stress: alternate inputs 0000 / 1111 every cycle -> y_q alternates 0/1 and y_rise pulses on every second cycle, never on two consecutive cycles.
